matmul_wrapper: RTL and testbench

- Sequential unsigned integer matrix multiplier: C = A × B.
- A is ROWS_A×COLS_A and B is COLS_A×COLS_B, both presented as flat packed buses.
- Operands are latched once after reset. The product is computed with one multiply-accumulate (MAC) per cycle, then held with out_valid until the next reset.
- Sits between a register/slave interface that supplies the operands and a consumer that reads the packed result plus status and cycle-count diagnostics.

---
 rtl/matmul_wrapper.sv | 173 +++++++++++++++++
 tb/tb_matmul_wrapper.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_wrapper.sv
// matmul_wrapper
// Sequential unsigned matrix multiplier computing C = A x B with a single
// multiply-accumulate per clock. Operands are captured once after reset,
// the product is built element by element, and the finished result is
// held with out_valid until the next reset.
//
// Ports:
//   clk        rising-edge clock
//   rstn       synchronous, active-high reset (1 = reset asserted)
//   a          packed A (ROWS_A x COLS_A), row-major, element [0][0] in MSBs
//   b          packed B (COLS_A x COLS_B), row-major, element [0][0] in MSBs
//   c          packed C (ROWS_A x COLS_B), row-major, registered
//   out_valid  c is complete and stable
//   out_ready  idle; a/b are captured on the next edge
//   counter    MAC cycles executed since reset
//   r          one-cycle pulse on the first DONE cycle
//   bu         busy, high while multiplying
module matmul_wrapper #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS_A     = 2,
  parameter int COLS_A     = 2,
  parameter int COLS_B     = 2
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic [ROWS_A*COLS_A*DATA_WIDTH-1:0]    a,
  input  logic [COLS_A*COLS_B*DATA_WIDTH-1:0]    b,
  output logic [ROWS_A*COLS_B*DATA_WIDTH-1:0]    c,
  output logic                                   out_valid,
  output logic                                   out_ready,
  output logic [31:0]                            counter,
  output logic                                   r,
  output logic                                   bu
);

  localparam int A_ELEMS = ROWS_A * COLS_A;
  localparam int B_ELEMS = COLS_A * COLS_B;
  localparam int C_ELEMS = ROWS_A * COLS_B;

  localparam int A_BITS = A_ELEMS * DATA_WIDTH;
  localparam int B_BITS = B_ELEMS * DATA_WIDTH;
  localparam int C_BITS = C_ELEMS * DATA_WIDTH;

  // Bit-offset widths for the variable part-selects into the packed buses
  localparam int AW = (A_BITS > 1) ? $clog2(A_BITS) : 1;
  localparam int BW = (B_BITS > 1) ? $clog2(B_BITS) : 1;
  localparam int CW = (C_BITS > 1) ? $clog2(C_BITS) : 1;

  // Loop index widths; a dimension of 1 still gets a 1-bit index
  localparam int IW = (ROWS_A > 1) ? $clog2(ROWS_A) : 1;
  localparam int KW = (COLS_A > 1) ? $clog2(COLS_A) : 1;
  localparam int JW = (COLS_B > 1) ? $clog2(COLS_B) : 1;

  localparam logic [IW-1:0] I_LAST = IW'(ROWS_A - 1);
  localparam logic [KW-1:0] K_LAST = KW'(COLS_A - 1);
  localparam logic [JW-1:0] J_LAST = JW'(COLS_B - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [A_BITS-1:0]     a_op;
  logic [B_BITS-1:0]     b_op;
  logic [C_BITS-1:0]     c_reg;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_next;
  logic [DATA_WIDTH-1:0] a_el;
  logic [DATA_WIDTH-1:0] b_el;
  logic [DATA_WIDTH-1:0] prod;
  logic [IW-1:0]         i;
  logic [KW-1:0]         k;
  logic [JW-1:0]         j;
  logic [AW-1:0]         a_sel;
  logic [BW-1:0]         b_sel;
  logic [CW-1:0]         c_sel;
  logic                  i_last;
  logic                  j_last;
  logic                  k_last;

  assign i_last = (i == I_LAST);
  assign j_last = (j == J_LAST);
  assign k_last = (k == K_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rstn) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state: capture in IDLE, leave CALC after the very last MAC, and
  // park in DONE until reset
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = CALC;
      CALC:    if (i_last && j_last && k_last) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // MAC datapath; the product is truncated to DATA_WIDTH before the add so
  // the whole sum wraps modulo 2^DATA_WIDTH
  always_comb begin
    a_sel    = AW'((A_ELEMS - 1 - (int'(i) * COLS_A + int'(k))) * DATA_WIDTH);
    b_sel    = BW'((B_ELEMS - 1 - (int'(k) * COLS_B + int'(j))) * DATA_WIDTH);
    c_sel    = CW'((C_ELEMS - 1 - (int'(i) * COLS_B + int'(j))) * DATA_WIDTH);
    a_el     = a_op[a_sel +: DATA_WIDTH];
    b_el     = b_op[b_sel +: DATA_WIDTH];
    prod     = a_el * b_el;
    acc_next = acc + prod;
  end

  // Operand capture, index walk (k innermost, then j, then i) and result
  // write-back. The element is written on its last k, so no extra cycle is
  // spent per element.
  always_ff @(posedge clk) begin
    if (rstn) begin
      a_op    <= '0;
      b_op    <= '0;
      c_reg   <= '0;
      acc     <= '0;
      counter <= '0;
      i       <= '0;
      j       <= '0;
      k       <= '0;
      r       <= 1'b0;
    end else begin
      r <= 1'b0;
      case (state)
        IDLE: begin
          a_op <= a;
          b_op <= b;
          acc  <= '0;
          i    <= '0;
          j    <= '0;
          k    <= '0;
        end
        CALC: begin
          counter <= counter + 32'd1;
          if (k_last) begin
            c_reg[c_sel +: DATA_WIDTH] <= acc_next;
            acc <= '0;
            k   <= '0;
            if (j_last) begin
              j <= '0;
              if (i_last) r <= 1'b1;
              else        i <= i + 1'b1;
            end else begin
              j <= j + 1'b1;
            end
          end else begin
            acc <= acc_next;
            k   <= k + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign c         = c_reg;
  assign out_valid = (state == DONE);
  assign out_ready = (state == IDLE);
  assign bu        = (state == CALC);

endmodule

// File: tb/tb_matmul_wrapper.sv
// tb_matmul_wrapper
// Directed bench for matmul_wrapper: a default 2x2x2 instance and a
// non-square 2x3x1 instance. Expected results come from a reference model
// and are queued when operands are driven, then popped when out_valid rises.
module tb_matmul_wrapper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        rstn = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] c;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] counter;
  logic        r;
  logic        bu;

  // Non-square instance: A is 2x3, B is 3x1
  logic        rstn2 = 1'b1;
  logic [47:0] a2 = '0;
  logic [23:0] b2 = '0;
  logic [15:0] c2;
  logic        out_valid2;
  logic        out_ready2;
  logic [31:0] counter2;
  logic        r2;
  logic        bu2;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  matmul_wrapper dut (
    .clk       (clk),
    .rstn      (rstn),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .counter   (counter),
    .r         (r),
    .bu        (bu)
  );

  matmul_wrapper #(
    .DATA_WIDTH (8),
    .ROWS_A     (2),
    .COLS_A     (3),
    .COLS_B     (1)
  ) dut2 (
    .clk       (clk),
    .rstn      (rstn2),
    .a         (a2),
    .b         (b2),
    .c         (c2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .counter   (counter2),
    .r         (r2),
    .bu        (bu2)
  );

  // Reference 2x2 by 2x2 product, each element wrapping modulo 256
  function automatic logic [31:0] model(input logic [31:0] av, input logic [31:0] bv);
    logic [31:0] res;
    logic [7:0]  s;
    res = '0;
    for (int ii = 0; ii < 2; ii++) begin
      for (int jj = 0; jj < 2; jj++) begin
        s = '0;
        for (int kk = 0; kk < 2; kk++)
          s = s + av[(3 - (ii * 2 + kk)) * 8 +: 8] * bv[(3 - (kk * 2 + jj)) * 8 +: 8];
        res[(3 - (ii * 2 + jj)) * 8 +: 8] = s;
      end
    end
    return res;
  endfunction

  // Single comparison point
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_c"}, 64'(c), 64'h0);
    checkOutput({tag, "_counter"}, 64'(counter), 64'h0);
    checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'h0);
    checkOutput({tag, "_out_ready"}, 64'(out_ready), 64'h1);
    checkOutput({tag, "_bu"}, 64'(bu), 64'h0);
    checkOutput({tag, "_r"}, 64'(r), 64'h0);
  endtask

  // Hold reset for ncyc edges with the new operands on the bus, then
  // release; the next rising edge is the capture edge
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv,
                               input int ncyc, input string tag);
    rstn = 1'b1;
    a    = av;
    b    = bv;
    exp_q.push_back(model(av, bv));
    repeat (ncyc) begin
      @(posedge clk);
      #1;
    end
    checkResetState(tag);
    rstn = 1'b0;
  endtask

  // Count edges to out_valid (bounded), optionally zero a mid-CALC, then
  // compare against the scoreboard and check the hold behaviour
  task automatic waitResult(input string tag, input int zero_a_at);
    int edges;
    int bu_cnt;
    int r_cnt;
    logic [31:0] exp_c;
    edges  = 0;
    bu_cnt = 0;
    r_cnt  = 0;
    while (!out_valid && edges < 50) begin
      @(posedge clk);
      #1;
      edges++;
      if (bu) bu_cnt++;
      if (r)  r_cnt++;
      if (edges == zero_a_at) a = '0;
    end
    checkOutput({tag, "_latency"}, 64'(edges), 64'd9);
    if (exp_q.size() == 0) exp_c = 32'hxxxxxxxx;
    else                   exp_c = exp_q.pop_front();
    checkOutput({tag, "_c"}, 64'(c), 64'(exp_c));
    checkOutput({tag, "_counter"}, 64'(counter), 64'd8);
    repeat (3) begin
      @(posedge clk);
      #1;
      if (r) r_cnt++;
    end
    checkOutput({tag, "_r_pulses"}, 64'(r_cnt), 64'd1);
    checkOutput({tag, "_bu_cycles"}, 64'(bu_cnt), 64'd8);
    checkOutput({tag, "_hold_valid"}, 64'(out_valid), 64'h1);
    checkOutput({tag, "_hold_ready"}, 64'(out_ready), 64'h0);
    checkOutput({tag, "_hold_c"}, 64'(c), 64'(exp_c));
    checkOutput({tag, "_hold_counter"}, 64'(counter), 64'd8);
  endtask

  initial begin
    int edges2;
    int bu2_cnt;
    int r2_cnt;
    logic [31:0] exp2;

    $display("[TB] start");

    // Basic product: {30,44,55,87}
    applyStimulus(32'h02040607, 32'h01040709, 2, "basic_rst");
    waitResult("basic", 0);
    checkOutput("basic_const", 64'(c), 64'h1E2C3757);

    // Wraparound: every element is (255*255 + 255*255) mod 256 = 2
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 2, "ovf_rst");
    waitResult("ovf", 0);
    checkOutput("ovf_const", 64'(c), 64'h02020202);

    // Identity on either side
    applyStimulus(32'h01000001, 32'h05060708, 2, "idl_rst");
    waitResult("ident_l", 0);
    applyStimulus(32'h05060708, 32'h01000001, 2, "idr_rst");
    waitResult("ident_r", 0);
    checkOutput("ident_const", 64'(c), 64'h05060708);

    // Operand change three cycles after capture is ignored
    applyStimulus(32'h02040607, 32'h01040709, 2, "chg_rst");
    waitResult("chg", 4);

    // Reset on the 4th CALC cycle, then recompute with new operands
    applyStimulus(32'h03010205, 32'h04020107, 2, "mid_rst0");
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    checkOutput("mid_bu", 64'(bu), 64'h1);
    checkOutput("mid_counter", 64'(counter), 64'd4);
    void'(exp_q.pop_back());
    applyStimulus(32'h01020304, 32'h05060708, 1, "mid_rst1");
    waitResult("mid_after", 0);

    // Non-square instance: A=[[1,2,3],[4,5,6]], B=[[1],[1],[1]] -> {6,15}
    a2 = 48'h010203040506;
    b2 = 24'h010101;
    exp_q.push_back(32'h0000060F);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput("ns_rst_c", 64'(c2), 64'h0);
    checkOutput("ns_rst_ready", 64'(out_ready2), 64'h1);
    rstn2   = 1'b0;
    edges2  = 0;
    bu2_cnt = 0;
    r2_cnt  = 0;
    while (!out_valid2 && edges2 < 50) begin
      @(posedge clk);
      #1;
      edges2++;
      if (bu2) bu2_cnt++;
      if (r2)  r2_cnt++;
    end
    exp2 = exp_q.pop_front();
    checkOutput("ns_latency", 64'(edges2), 64'd7);
    checkOutput("ns_c", 64'(c2), 64'(exp2[15:0]));
    checkOutput("ns_counter", 64'(counter2), 64'd6);
    checkOutput("ns_bu_cycles", 64'(bu2_cnt), 64'd6);
    checkOutput("ns_r_pulses", 64'(r2_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
